// File: rtl/counter_trig_sched.sv
// Programmable trigger sequencer: walks a command table, firing counter triggers.
// Optional looping support is enabled by defining COUNTER_TRIG_SCHED_LOOP_EN.
module counter_trig_sched #(
    parameter int COUNTER_NUM = 4,
    parameter int DEPTH       = 8,
    parameter int DLY_WIDTH   = 16
) (
    input  logic                       i_pclk,
    input  logic                       i_prst,
    input  logic                       i_cmd_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_cmd_wr_addr,
    input  logic [DLY_WIDTH-1:0]       i_cmd_wr_delay,
    input  logic [1:0]                 i_cmd_wr_op,
    input  logic                       i_cmd_wr_global,
    input  logic [COUNTER_NUM-1:0]     i_cmd_wr_mask,
    input  logic                       i_cmd_wr_last,
    input  logic [3:0]                 i_pulse_width,
    input  logic                       i_seq_start,
    input  logic                       i_seq_abort,
    input  logic                       i_seq_loop,
    output logic [COUNTER_NUM-1:0]     o_single_start_trigger,
    output logic [COUNTER_NUM-1:0]     o_single_stop_trigger,
    output logic [COUNTER_NUM-1:0]     o_single_clear_trigger,
    output logic [COUNTER_NUM-1:0]     o_single_reset_trigger,
    output logic                       o_global_start_trigger,
    output logic                       o_global_stop_trigger,
    output logic                       o_global_clear_trigger,
    output logic                       o_global_reset_trigger,
    output logic                       o_busy,
    output logic [$clog2(DEPTH)-1:0]   o_cur_idx,
    output logic                       o_done,
    output logic                       o_wr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_MAX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        FIRE,
        DONE
    } state_t;

    state_t state;

    logic [DLY_WIDTH-1:0]   tbl_delay [DEPTH];
    logic [1:0]             tbl_op    [DEPTH];
    logic                   tbl_glob  [DEPTH];
    logic [COUNTER_NUM-1:0] tbl_mask  [DEPTH];
    logic                   tbl_last  [DEPTH];

    logic [AW-1:0]                   idx;
    logic [DLY_WIDTH-1:0]            dly_cnt;
    logic [3:0]                      wid_cnt;
    logic [3:0]                      wid_lat;
    logic [3:0][COUNTER_NUM-1:0]     single_q;
    logic [3:0]                      global_q;
    logic                            loop_en;
    logic                            end_entry;

`ifdef COUNTER_TRIG_SCHED_LOOP_EN
    assign loop_en = i_seq_loop;
`else
    logic unused_loop;
    assign unused_loop = i_seq_loop;
    assign loop_en     = 1'b0;
`endif

    assign end_entry = tbl_last[idx] || (idx == IDX_MAX);

    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_delay[i] <= '0;
                tbl_op[i]    <= '0;
                tbl_glob[i]  <= 1'b0;
                tbl_mask[i]  <= '0;
                tbl_last[i]  <= 1'b0;
            end
        end else if (i_cmd_wr_en && state == IDLE) begin
            tbl_delay[i_cmd_wr_addr] <= i_cmd_wr_delay;
            tbl_op[i_cmd_wr_addr]    <= i_cmd_wr_op;
            tbl_glob[i_cmd_wr_addr]  <= i_cmd_wr_global;
            tbl_mask[i_cmd_wr_addr]  <= i_cmd_wr_mask;
            tbl_last[i_cmd_wr_addr]  <= i_cmd_wr_last;
        end
    end

    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) begin
            state    <= IDLE;
            idx      <= '0;
            dly_cnt  <= '0;
            wid_cnt  <= '0;
            wid_lat  <= '0;
            single_q <= '0;
            global_q <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_wr_err <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            o_wr_err <= i_cmd_wr_en && (state != IDLE);
            if (i_seq_abort) begin
                state    <= IDLE;
                idx      <= '0;
                single_q <= '0;
                global_q <= '0;
                o_busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_seq_start) begin
                            idx    <= '0;
                            state  <= LOAD;
                            o_busy <= 1'b1;
                        end
                    end
                    LOAD: begin
                        dly_cnt <= tbl_delay[idx];
                        state   <= WAIT;
                    end
                    WAIT: begin
                        if (dly_cnt == '0) begin
                            state   <= FIRE;
                            wid_cnt <= '0;
                            wid_lat <= i_pulse_width;
                            if (tbl_glob[idx])
                                global_q[tbl_op[idx]] <= 1'b1;
                            else
                                single_q[tbl_op[idx]] <= tbl_mask[idx];
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end
                    FIRE: begin
                        if (wid_cnt == wid_lat) begin
                            single_q <= '0;
                            global_q <= '0;
                            if (!end_entry) begin
                                idx   <= idx + 1'b1;
                                state <= LOAD;
                            end else if (loop_en) begin
                                idx   <= '0;
                                state <= LOAD;
                            end else begin
                                state  <= DONE;
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            wid_cnt <= wid_cnt + 1'b1;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_single_start_trigger = single_q[0];
    assign o_single_stop_trigger  = single_q[1];
    assign o_single_clear_trigger = single_q[2];
    assign o_single_reset_trigger = single_q[3];
    assign o_global_start_trigger = global_q[0];
    assign o_global_stop_trigger  = global_q[1];
    assign o_global_clear_trigger = global_q[2];
    assign o_global_reset_trigger = global_q[3];
    assign o_cur_idx              = idx;

endmodule

// File: tb/tb_counter_trig_sched.sv
// Bench for counter_trig_sched: directed vector table, hand sequences, and
// randomized tables checked against a timeline model of the sequencer.
module tb_counter_trig_sched;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic wr_en;
    logic [2:0] wr_addr;
    logic [15:0] wr_delay;
    logic [1:0] wr_op;
    logic wr_global;
    logic [3:0] wr_mask;
    logic wr_last;
    logic [3:0] pw;
    logic start, abort, loop;
    logic [3:0] s_start, s_stop, s_clear, s_reset;
    logic g_start, g_stop, g_clear, g_reset;
    logic busy, done, wr_err;
    logic [2:0] cur_idx;

    int checks = 0;
    int failures = 0;

    counter_trig_sched #(.COUNTER_NUM(4), .DEPTH(DEPTH), .DLY_WIDTH(16)) dut (
        .i_pclk(clk), .i_prst(rst),
        .i_cmd_wr_en(wr_en), .i_cmd_wr_addr(wr_addr),
        .i_cmd_wr_delay(wr_delay), .i_cmd_wr_op(wr_op),
        .i_cmd_wr_global(wr_global), .i_cmd_wr_mask(wr_mask),
        .i_cmd_wr_last(wr_last), .i_pulse_width(pw),
        .i_seq_start(start), .i_seq_abort(abort), .i_seq_loop(loop),
        .o_single_start_trigger(s_start), .o_single_stop_trigger(s_stop),
        .o_single_clear_trigger(s_clear), .o_single_reset_trigger(s_reset),
        .o_global_start_trigger(g_start), .o_global_stop_trigger(g_stop),
        .o_global_clear_trigger(g_clear), .o_global_reset_trigger(g_reset),
        .o_busy(busy), .o_cur_idx(cur_idx), .o_done(done), .o_wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // Table contents as the bench believes them to be
    int         m_delay [DEPTH];
    logic [1:0] m_op    [DEPTH];
    bit         m_glob  [DEPTH];
    logic [3:0] m_mask  [DEPTH];
    bit         m_last  [DEPTH];

    // Timeline of visited entries, relative to the start edge
    int w_idx[$];
    int w_load[$];
    int w_rise[$];
    int end_t;

    typedef struct {
        int sc;
        int t;
        bit fire;
        logic [1:0] op;
        bit g;
        logic [3:0] mask;
        bit b;
        bit d;
        int idx;
    } vec_t;
    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] act_vec();
        return {s_start, s_stop, s_clear, s_reset,
                g_start, g_stop, g_clear, g_reset, busy, done};
    endfunction

    function automatic logic [21:0] exp_vec(bit f, logic [1:0] op, bit g,
                                            logic [3:0] mk, bit b, bit d);
        logic [3:0] s0, s1, s2, s3, gg;
        s0 = '0; s1 = '0; s2 = '0; s3 = '0; gg = '0;
        if (f) begin
            if (g) gg[op] = 1'b1;
            else begin
                case (op)
                    2'd0: s0 = mk;
                    2'd1: s1 = mk;
                    2'd2: s2 = mk;
                    default: s3 = mk;
                endcase
            end
        end
        return {s0, s1, s2, s3, gg[0], gg[1], gg[2], gg[3], b, d};
    endfunction

    task automatic chk(input string nm, input int t,
                       input logic [21:0] a, input logic [21:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, a, e);
        end
    endtask

    task automatic chk1(input string nm, input int t, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, a, e);
        end
    endtask

    task automatic wr(input int a, input int d, input logic [1:0] op,
                      input bit g, input logic [3:0] mk, input bit lst);
        wr_en = 1'b1; wr_addr = 3'(a); wr_delay = 16'(d);
        wr_op = op; wr_global = g; wr_mask = mk; wr_last = lst;
        step();
        wr_en = 1'b0;
        m_delay[a] = d; m_op[a] = op; m_glob[a] = g;
        m_mask[a] = mk; m_last[a] = lst;
        chk1("wr_err_idle", 0, int'(wr_err), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_delay[i] = 0; m_op[i] = 2'd0; m_glob[i] = 1'b0;
            m_mask[i] = 4'd0; m_last[i] = 1'b0;
        end
    endtask

    task automatic build(input int W, input bit lp, input int horizon);
        int t_load, i, rise, fin;
        bit eff;
        eff = lp;
`ifndef COUNTER_TRIG_SCHED_LOOP_EN
        eff = 1'b0;
`endif
        w_idx.delete(); w_load.delete(); w_rise.delete();
        end_t = -1; t_load = 0; i = 0;
        while (1) begin
            rise = t_load + m_delay[i] + 2;
            w_idx.push_back(i); w_load.push_back(t_load); w_rise.push_back(rise);
            if (rise > horizon) break;
            fin = rise + W + 1;
            if (m_last[i] || i == DEPTH - 1) begin
                if (eff) begin
                    i = 0; t_load = fin;
                end else begin
                    end_t = fin;
                    break;
                end
            end else begin
                i = i + 1; t_load = fin;
            end
        end
    endtask

    task automatic expect_at(input int t, input int W,
                             output logic [21:0] e, output int ei);
        bit b, d, f;
        int kf;
        b = (end_t < 0) || (t < end_t);
        d = (t == end_t);
        f = 1'b0; kf = 0; ei = -1;
        for (int k = 0; k < w_idx.size(); k++) begin
            if (w_rise[k] <= t && t <= w_rise[k] + W) begin
                f = 1'b1; kf = k;
            end
            if (b && w_load[k] <= t) ei = w_idx[k];
        end
        if (f)
            e = exp_vec(1'b1, m_op[w_idx[kf]], m_glob[w_idx[kf]],
                        m_mask[w_idx[kf]], b, d);
        else
            e = exp_vec(1'b0, 2'd0, 1'b0, 4'd0, b, d);
    endtask

    task automatic run_seq(input int W, input bit lp, input int horizon,
                           input int abort_in, input int wchg_t, input string nm);
        int last_t, ab, ei;
        logic [21:0] e;
        pw = 4'(W); loop = lp;
        build(W, lp, horizon);
        last_t = (end_t >= 0) ? end_t + 2 : horizon;
        ab = (abort_in > last_t) ? -1 : abort_in;
        if (end_t < 0 && ab < 0) ab = horizon;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= last_t; t++) begin
            expect_at(t, W, e, ei);
            chk(nm, t, act_vec(), e);
            if (ei >= 0) chk1({nm, "_idx"}, t, int'(cur_idx), ei);
            if (t == wchg_t) pw = 4'(15 - W);
            if (t == ab) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk({nm, "_abort"}, t + 1, act_vec(), 22'd0);
                chk1({nm, "_abort_idx"}, t + 1, int'(cur_idx), 0);
                pw = 4'(W);
                return;
            end
            step();
        end
        pw = 4'(W);
    endtask

    task automatic add_vec(input int sc, input int t, input bit f,
                           input logic [1:0] op, input bit g, input logic [3:0] mk,
                           input bit b, input bit d, input int ix);
        vec_t v;
        v.sc = sc; v.t = t; v.fire = f; v.op = op; v.g = g;
        v.mask = mk; v.b = b; v.d = d; v.idx = ix;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_delay = '0; wr_op = '0;
        wr_global = 1'b0; wr_mask = '0; wr_last = 1'b0; pw = '0;
        start = 1'b0; abort = 1'b0; loop = 1'b0;
        clear_model();

        // Scenario 1: single global start, D=3, W=0
        add_vec(1, 0, 0, 2'd0, 0, 4'h0, 1, 0, 0);
        add_vec(1, 4, 0, 2'd0, 0, 4'h0, 1, 0, 0);
        add_vec(1, 5, 1, 2'd0, 1, 4'h0, 1, 0, 0);
        add_vec(1, 6, 0, 2'd0, 0, 4'h0, 0, 1, -1);
        add_vec(1, 7, 0, 2'd0, 0, 4'h0, 0, 0, -1);
        // Scenario 2: three single-trigger entries, W=3
        add_vec(2, 3, 0, 2'd0, 0, 4'h0, 1, 0, 0);
        add_vec(2, 4, 1, 2'd0, 0, 4'h1, 1, 0, 0);
        add_vec(2, 7, 1, 2'd0, 0, 4'h1, 1, 0, 0);
        add_vec(2, 8, 0, 2'd0, 0, 4'h0, 1, 0, 1);
        add_vec(2, 9, 0, 2'd0, 0, 4'h0, 1, 0, 1);
        add_vec(2, 10, 1, 2'd2, 0, 4'h6, 1, 0, 1);
        add_vec(2, 13, 1, 2'd2, 0, 4'h6, 1, 0, 1);
        add_vec(2, 14, 0, 2'd0, 0, 4'h0, 1, 0, 2);
        add_vec(2, 20, 0, 2'd0, 0, 4'h0, 1, 0, 2);
        add_vec(2, 21, 1, 2'd1, 0, 4'hF, 1, 0, 2);
        add_vec(2, 24, 1, 2'd1, 0, 4'hF, 1, 0, 2);
        add_vec(2, 25, 0, 2'd0, 0, 4'h0, 0, 1, -1);
        add_vec(2, 26, 0, 2'd0, 0, 4'h0, 0, 0, -1);

        step(); step();
        chk("reset_outs", 0, act_vec(), 22'd0);
        chk1("reset_idx", 0, int'(cur_idx), 0);
        chk1("reset_wr_err", 0, int'(wr_err), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int sc = 1; sc <= 2; sc++) begin
            if (sc == 1) begin
                wr(0, 3, 2'd0, 1, 4'h0, 1);
                pw = 4'd0;
            end else begin
                wr(0, 2, 2'd0, 0, 4'h1, 0);
                wr(1, 0, 2'd2, 0, 4'h6, 0);
                wr(2, 5, 2'd1, 0, 4'hF, 1);
                pw = 4'd3;
            end
            start = 1'b1;
            step();
            start = 1'b0;
            for (int t = 0; t <= 26; t++) begin
                foreach (vecs[i]) begin
                    if (vecs[i].sc == sc && vecs[i].t == t) begin
                        chk($sformatf("vec_sc%0d", sc), t, act_vec(),
                            exp_vec(vecs[i].fire, vecs[i].op, vecs[i].g,
                                    vecs[i].mask, vecs[i].b, vecs[i].d));
                        if (vecs[i].idx >= 0)
                            chk1($sformatf("vec_sc%0d_idx", sc), t,
                                 int'(cur_idx), vecs[i].idx);
                    end
                end
                step();
            end
        end

        // Abort during FIRE of entry 1, then a clean restart
        run_seq(7, 0, 200, 16, -1, "abort_fire");
        run_seq(7, 0, 200, -1, -1, "restart");

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort", 0, act_vec(), 22'd0);
        step();
        chk("start_abort_hold", 1, act_vec(), 22'd0);

        // Write while busy is rejected
        clear_model();
        wr(0, 3, 2'd0, 1, 4'h0, 1);
        pw = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_delay = 16'd1; wr_op = 2'd3;
        wr_global = 1'b0; wr_mask = 4'hF; wr_last = 1'b0;
        step();
        wr_en = 1'b0;
        chk1("wr_err_pulse", 1, int'(wr_err), 1);
        step();
        chk1("wr_err_clear", 2, int'(wr_err), 0);
        for (int i = 0; i < 30 && busy; i++) step();
        chk1("busy_timeout", 0, int'(busy), 0);
        step(); step();
        run_seq(0, 0, 200, -1, -1, "replay");

        // Pulse width change during FIRE has no effect on that entry
        wr(0, 1, 2'd3, 1, 4'h0, 1);
        run_seq(2, 0, 200, -1, 3, "pw_change");

        // Looping: two entries
        wr(0, 1, 2'd0, 0, 4'h3, 0);
        wr(1, 2, 2'd1, 1, 4'h0, 1);
        run_seq(1, 1, 60, -1, -1, "loop");

        // Full walk with no last bit and a mask=0 entry
        for (int a = 0; a < DEPTH; a++)
            wr(a, a % 3, 2'(a), 1'b0, (a == 3) ? 4'h0 : 4'(a + 1), 0);
        run_seq(1, 0, 300, -1, -1, "full_walk");

        // Randomized tables
        for (int it = 0; it < 12; it++) begin
            int ab;
            for (int a = 0; a < DEPTH; a++)
                wr(a, $urandom_range(0, 6), 2'($urandom_range(0, 3)),
                   ($urandom % 4) == 0, 4'($urandom), ($urandom % 3) == 0);
            ab = (($urandom % 3) == 0) ? $urandom_range(0, 40) : -1;
            run_seq($urandom_range(0, 4), 1'($urandom % 2), 150, ab, -1,
                    $sformatf("rand%0d", it));
        end

        // Reset mid-FIRE clears outputs at once and empties the table
        wr(0, 0, 2'd2, 1, 4'h0, 1);
        pw = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre_reset_fire", 2, act_vec(),
            exp_vec(1'b1, 2'd2, 1'b1, 4'h0, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 0, act_vec(), 22'd0);
        chk1("async_reset_idx", 0, int'(cur_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        clear_model();
        run_seq(0, 0, 200, -1, -1, "cleared_table");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_trig_sched.md
# counter_trig_sched

Programmable trigger sequencer for the counter array, in the APB register clock domain. It holds a small command table. Once started, it walks the table entry by entry: it waits a programmed delay, then drives single-counter or global start/stop/clear/reset trigger levels for a programmed width. Its outputs feed the per-counter trigger inputs of `counter_all`, which re-synchronises them into each counter clock. The programmable pulse width lets slow counter clocks capture the pulses reliably.

## Interface
Parameters:
- COUNTER_NUM, 4, number of counters driven
- DEPTH, 8, command table entries (power of two, ≥2)
- DLY_WIDTH, 16, delay field width

Ports:
- i_pclk  in  1  register clock
- i_prst  in  1  asynchronous, active-high reset
- i_cmd_wr_en  in  1  write the table entry at i_cmd_wr_addr
- i_cmd_wr_addr  in  $clog2(DEPTH)  entry index
- i_cmd_wr_delay  in  DLY_WIDTH  idle cycles before the trigger fires
- i_cmd_wr_op  in  2  trigger type: 0 start, 1 stop, 2 clear, 3 reset
- i_cmd_wr_global  in  1  1: drive the global trigger (mask ignored); 0: drive single triggers selected by mask
- i_cmd_wr_mask  in  COUNTER_NUM  counter select for single triggers
- i_cmd_wr_last  in  1  entry terminates the sequence
- i_pulse_width  in  4  trigger high time = value+1 cycles
- i_seq_start  in  1  start pulse
- i_seq_abort  in  1  abort pulse
- i_seq_loop  in  1  restart at entry 0 after the last entry
- o_single_start_trigger / o_single_stop_trigger / o_single_clear_trigger / o_single_reset_trigger  out  COUNTER_NUM  registered trigger levels
- o_global_start_trigger / o_global_stop_trigger / o_global_clear_trigger / o_global_reset_trigger  out  1  registered trigger levels
- o_busy  out  1  sequence in progress
- o_cur_idx  out  $clog2(DEPTH)  entry being processed
- o_done  out  1  one-cycle pulse at sequence completion
- o_wr_err  out  1  one-cycle pulse when a write is rejected

## Operation
- Reset:
  - All table fields are 0; state IDLE; o_cur_idx 0.
  - All outputs are 0.
- Table writes:
  - Accepted only in IDLE.
  - A write while o_busy=1 is dropped, and o_wr_err pulses on the next cycle.
- States:
  - IDLE: on i_seq_start, set idx=0 and go to LOAD.
  - LOAD: one cycle; set dly_cnt = delay[idx]; go to WAIT.
  - WAIT: if dly_cnt==0 go to FIRE, else decrement dly_cnt.
  - FIRE: selected trigger outputs are high; wid_cnt counts to i_pulse_width.
  - End of FIRE:
    - if last[idx] or idx==DEPTH-1: go to LOAD with idx=0 when looping, otherwise go to DONE;
    - else go to LOAD with idx+1.
  - DONE: one cycle with o_done=1, then IDLE.
- Trigger selection in FIRE:
  - global=1: only o_global_<op> is driven.
  - global=0: o_single_<op> = mask.
  - Exactly one op group is active; all other trigger outputs are 0.
- Zero conditions:
  - A non-global entry with mask=0 fires nothing but keeps its timing.
  - delay=0 is legal: WAIT lasts exactly one cycle.
- i_pulse_width is sampled on entry to FIRE; changes during FIRE have no effect on that entry.
- i_seq_abort:
  - From any state: go to IDLE on the next edge, with all trigger outputs 0 from that edge.
  - idx returns to 0; o_done is not asserted.
  - If abort and start occur in the same cycle, abort wins.
- i_seq_start while busy is ignored.
- o_busy = 1 in LOAD, WAIT and FIRE.
- o_cur_idx follows idx.

## Timing
- All outputs are registered on the rising edge of i_pclk.
- Start to first trigger: with i_seq_start sampled at edge N and entry 0 delay D, trigger outputs rise after edge N+D+2.
- Trigger high time: exactly W+1 cycles, where W is i_pulse_width.
- Spacing between consecutive entries: the rising edge of entry k+1 follows the rising edge of entry k by W+D(k+1)+3 cycles.
- o_done is high in the cycle following the last FIRE cycle; o_busy falls at the same edge.
- Looping: LOAD of entry 0 directly follows FIRE of the last entry; DONE is skipped and o_busy stays 1.
- Reset asserted mid-sequence: outputs clear asynchronously and the table is cleared.

## Configuration
- Macro COUNTER_TRIG_SCHED_LOOP_EN:
  - Defined: i_seq_loop is honoured as described above.
  - Undefined: i_seq_loop is ignored (port kept); every sequence terminates through DONE.

## Test plan
- Entry0 {D=3, start, global}, last=1, W=0; start pulse: o_global_start_trigger high for exactly 1 cycle, 5 edges after start; then o_done pulse; o_busy returns to 0.
- Entries 0..2 {D=2 / 0 / 5, ops start / clear / stop, masks 4'b0001 / 4'b0110 / 4'b1111}, last on entry 2, W=3: o_single_* show those masks for 4 cycles each, rise-to-rise spacing 6 then 11 cycles, o_cur_idx steps 0→1→2.
- Abort during FIRE of entry 1 with W=7: triggers drop after the next edge, o_busy=0, no o_done; a restart begins again at entry 0.
- Write to the table while busy: entry is unchanged (read back via replay), o_wr_err pulses once; simultaneous start and abort in IDLE keeps IDLE.
- Loop=1 with the macro defined, 2 entries: the sequence repeats ≥3 times with no o_done. With the macro undefined, the same stimulus yields a single pass plus o_done.
- All DEPTH entries with last=0: the sequence ends after entry DEPTH-1; a mask=0 entry produces no output but consumes its delay plus W+1 cycles.
